// File: rtl/xnor_acc_pkg.sv
// Shared definitions for the XNOR/AND popcount accumulator: FSM encoding,
// lane decode and partial-sum width derivation.
package xnor_acc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_ACC   = 2'd0;
  localparam state_t S_DRAIN = 2'd1;
  localparam state_t S_OUT   = 2'd2;

  // Wide enough for N lanes of -2 each (worst-case illegal 2'b10 decode).
  function automatic int ps_width(input int n_lanes);
    return $clog2(n_lanes) + 2;
  endfunction

  function automatic logic signed [1:0] lane_decode(input logic [1:0] lane, input logic bin);
    logic signed [1:0] val;
    if (bin) begin
      val = {1'b0, lane[0]};
    end else begin
      val = lane;
    end
    return val;
  endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational reduction of N_LANES 2-bit multiplier products into one
// signed partial sum, decoded per lane according to the group mode.
module lane_adder_tree
  import xnor_acc_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int PS_W    = ps_width(N_LANES)
) (
  input  logic [2*N_LANES-1:0]  mul,
  input  logic                  bin,
  output logic signed [PS_W-1:0] sum
);

  // Pairwise in-place reduction: level w folds 2w nodes into w nodes.
  always_comb begin
    logic signed [PS_W-1:0] node [N_LANES];
    for (int k = 0; k < N_LANES; k++) begin
      node[k] = PS_W'(lane_decode(mul[2*k +: 2], bin));
    end
    for (int w = N_LANES / 2; w >= 1; w = w / 2) begin
      for (int k = 0; k < w; k++) begin
        node[k] = node[2*k] + node[2*k+1];
      end
    end
    sum = node[0];
  end

endmodule

// File: rtl/xnor_popcount_accumulator.sv
// Two-stage beat reducer and shift-accumulator producing one signed result
// per group; binary groups get the 2*pop - nbits XNOR correction.
module xnor_popcount_accumulator
  import xnor_acc_pkg::*;
#(
  parameter int N_LANES = 16,
  parameter int ACC_W   = 24,
  parameter int SH_W    = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*N_LANES-1:0] in_mul,
  input  logic [SH_W-1:0]      in_shift,
  input  logic                 in_bin,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data
);

  localparam int PS_W = ps_width(N_LANES);

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   grp_open_q, grp_open_d;
  logic                   grp_bin_q, grp_bin_d;
  logic                   s1_valid_q, s1_valid_d;
  logic signed [PS_W-1:0] psum_q, psum_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic                   last_q, last_d;
  logic                   bin_q, bin_d;
  logic                   first_q, first_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_W-1:0]       out_data_q, out_data_d;

  logic                   accept_s;
  logic                   first_s;
  logic                   beat_bin_s;
  logic signed [PS_W-1:0] tree_sum_s;
  logic [ACC_W-1:0]       addend_s;
  logic [ACC_W-1:0]       acc_next_s;
  logic [CNT_W-1:0]       cnt_next_s;
  logic [ACC_W-1:0]       bin_result_s;

  assign accept_s   = in_valid && in_ready_q;
  assign first_s    = !grp_open_q;
  // The group flag is taken from the first beat only and held for the rest.
  assign beat_bin_s = first_s ? in_bin : grp_bin_q;

  lane_adder_tree #(
    .N_LANES (N_LANES),
    .PS_W    (PS_W)
  ) u_tree (
    .mul (in_mul),
    .bin (beat_bin_s),
    .sum (tree_sum_s)
  );

  // Stage 1: capture the reduced beat and track group boundaries.
  always_comb begin
    psum_d     = psum_q;
    shift_d    = shift_q;
    last_d     = last_q;
    bin_d      = bin_q;
    first_d    = first_q;
    grp_open_d = grp_open_q;
    grp_bin_d  = grp_bin_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      psum_d     = tree_sum_s;
      shift_d    = in_shift;
      last_d     = in_last;
      bin_d      = beat_bin_s;
      first_d    = first_s;
      grp_open_d = !in_last;
      grp_bin_d  = beat_bin_s;
    end else begin
      s1_valid_d = 1'b0;
    end
  end

  assign addend_s     = ACC_W'(psum_q) << (bin_q ? {SH_W{1'b0}} : shift_q);
  assign acc_next_s   = (first_q ? {ACC_W{1'b0}} : acc_q) + addend_s;
  assign cnt_next_s   = (first_q ? {CNT_W{1'b0}} : cnt_q)
                      + (bin_q ? CNT_W'(N_LANES) : {CNT_W{1'b0}});
  assign bin_result_s = {acc_next_s[ACC_W-2:0], 1'b0} - ACC_W'(cnt_next_s);

  // Stage 2: accumulate, finalise on the last beat, release on handshake.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s1_valid_q) begin
      if (last_q) begin
        acc_d       = {ACC_W{1'b0}};
        cnt_d       = {CNT_W{1'b0}};
        out_valid_d = 1'b1;
        out_data_d  = bin_q ? bin_result_s : acc_next_s;
      end else begin
        acc_d = acc_next_s;
        cnt_d = cnt_next_s;
      end
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Flow control: input is closed from last-beat acceptance until output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC: begin
        if (accept_s && in_last) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ACC;
        end
      end
      S_DRAIN: begin
        if (s1_valid_q && last_q) begin
          state_d = S_OUT;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          state_d = S_ACC;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_ACC;
    endcase
    in_ready_d = (state_d == S_ACC);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      in_ready_q  <= 1'b1;
      grp_open_q  <= 1'b0;
      grp_bin_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      psum_q      <= {PS_W{1'b0}};
      shift_q     <= {SH_W{1'b0}};
      last_q      <= 1'b0;
      bin_q       <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {ACC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      grp_open_q  <= grp_open_d;
      grp_bin_q   <= grp_bin_d;
      s1_valid_q  <= s1_valid_d;
      psum_q      <= psum_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      bin_q       <= bin_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
